seg_disp_driver: RTL and testbench
==================================

// Module: seg_disp_driver
// PURPOSE
//  Downstream display stage for num_syst: takes a 16-bit value plus a base select,
//  converts it to four digits and drives a multiplexed 4-digit common-anode 7-seg display.
//  - Hex is a direct nibble split.
//  - Decimal is a sequential double-dabble conversion (16 iterations).
//  - The display keeps showing the previous value until the new conversion finishes.
// PARAMETERS
//  REFRESH_DIV  50000  clocks per digit slot; must be >= 2; bench uses 4
//  DATA_W       16     input width; fixed for this block
// PORTS
//  clk       in   1   system clock, all logic on rising edge
//  rst_n     in   1   asynchronous active-low reset (driven from KEY0)
//  in_valid  in   1   new value offered
//  in_ready  out  1   block can accept; transfer when in_valid && in_ready at a clk edge
//  in_data   in   16  value to display
//  in_base   in   1   0 = hex, 1 = decimal; sampled with in_data
//  blank_lz  in   1   1 = blank leading zeros (digit 0 always shown); sampled with in_data
//  seg_n     out  7   active-low segments {g,f,e,d,c,b,a}, registered
//  dp_n      out  1   active-low decimal point; lit on digit 0 when the shown value is hex
//  an_n      out  4   active-low digit select, one-hot low, registered
//  ovf       out  1   1 = last accepted decimal value > 9999
// BEHAVIOUR
//  Reset (async, any state):
//  - Outputs: seg_n=7'h7F, dp_n=1, an_n=4'b1110, ovf=0, in_ready=1.
//  - Display register all blank; FSM=IDLE; scan counter=0; digit index=0.
//  - A conversion in progress is aborted; nothing partial is ever displayed.
//  FSM IDLE / CONV / LATCH; in_ready=1 only in IDLE.
//  - IDLE: on accept, register in_data/in_base/blank_lz.
//    - Hex goes to LATCH.
//    - Decimal loads the double-dabble shifter and goes to CONV with iteration count 0.
//  - CONV: one shift/add-3 iteration per clock, 16 clocks, then LATCH.
//  - LATCH: in one clock, write all 4 digit codes and the blank flags to the display
//    register, update ovf, and return to IDLE.
//    - The update is atomic: no torn mixes of old and new digits.
//  - Latency, accept edge to display register update:
//    - hex: 1 clock, plus 1 clock for in_ready to return high;
//    - decimal: 17 clocks, plus 1 clock for in_ready to return high.
//  - in_valid while in_ready=0 is ignored; the value is not queued.
//  - Back-to-back accepts are allowed: IDLE accepts again on the first clock it is re-entered.
//  Digit values and overflow:
//  - Hex: digit k = in_data[4k+3:4k].
//  - Decimal: 5 BCD digits are produced.
//    - If the top BCD digit is nonzero: ovf=1, all four digits show '-' (pattern 7'h40),
//      blanking is ignored, dp off.
//    - Otherwise ovf=0 and the low 4 BCD digits are shown.
//  - Leading-zero blanking, when the sampled blank_lz=1:
//    - digits above the highest nonzero digit are blank (seg_n=7'h7F);
//    - digit 0 is never blanked, so the value 0 shows '0'.
//  - ovf changes only in LATCH; a hex load clears it.
//  Segment patterns (active-high {g..a}); seg_n is the inverse:
//  - 0:3F  1:06  2:5B  3:4F  4:66  5:6D  6:7D  7:07
//  - 8:7F  9:6F  A:77  b:7C  C:39  d:5E  E:79  F:71
//  Scan:
//  - A free-running counter counts 0..REFRESH_DIV-1.
//  - On the wrap, the digit index advances 0->1->2->3->0.
//  - Registered an_n, seg_n and dp_n update on that same edge for the new index.
//  - The scan runs independently of the FSM and is never stalled by conversion.
// TESTING (REFRESH_DIV=4)
//  1. Assert rst_n=0 for 3 clocks -> seg_n=7F, an_n=1110, dp_n=1, in_ready=1, ovf=0,
//     all four slots blank.
//  2. Hex 16'h1F2A, blank_lz=0 -> in_ready low for 1 clock; display per slot:
//     - an_n=1110: seg_n=08 (A), dp_n=0
//     - an_n=1101: seg_n=24 (2)
//     - an_n=1011: seg_n=0E (F)
//     - an_n=0111: seg_n=79 (1)
//  3. Decimal 16'h00FF, blank_lz=1 -> in_ready low for exactly 17 clocks; then:
//     - digits 5,5,2 on digits 0..2: seg_n=12,12,24
//     - digit 3 blank (seg_n=7F), dp_n=1
//  4. Decimal 16'd10000 -> ovf=1, every digit seg_n=3F;
//     then hex 16'h0000 with blank_lz=1 -> ovf=0, digit 0 seg_n=40, digits 1..3 seg_n=7F.
//  5. Hold in_valid=1 with in_data changed to 16'd42 during CONV of 16'd1234
//     -> display 1234, then 42 accepted on the first IDLE clock.
//  6. Pulse rst_n low at CONV iteration 8 of 16'd9999
//     -> display blank, in_ready=1 on release, no partial digits ever shown.

Source files
------------

// File: rtl/seg_disp_driver.sv
// Multiplexed 4-digit common-anode 7-segment driver: hex nibble split or sequential
// double-dabble decimal conversion, with an atomically updated display register.
module seg_disp_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_base,
  input  logic              blank_lz,
  output logic [6:0]        seg_n,
  output logic              dp_n,
  output logic [3:0]        an_n,
  output logic              ovf
);

  localparam int SH_W = 20 + DATA_W;
  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [4:0] ITER_LAST = 5'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

  state_t            state;
  logic [DATA_W-1:0] data_q;
  logic              base_q;
  logic              blz_q;
  logic [SH_W-1:0]   dd_q;
  logic [4:0]        iter_q;
  logic [6:0]        disp_q [4];
  logic              disp_hex_q;

  logic [SH_W-1:0]   dd_adj;
  logic [SH_W-1:0]   dd_next;
  logic [3:0]        dig [4];
  logic [6:0]        new_seg [4];
  logic              top_nz;
  logic              nz_above;
  logic [3:0]        blank;

  logic [CNT_W-1:0]  scan_cnt;
  logic [1:0]        idx;
  logic [1:0]        idx_next;

  // Handshake: a value transfers on a rising clk edge when in_valid && in_ready;
  // in_ready is high only in IDLE and an offer made while busy is simply not taken.
  assign in_ready = (state == IDLE);

  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    case (d)
      4'h0: seg_lut = 7'h3F;
      4'h1: seg_lut = 7'h06;
      4'h2: seg_lut = 7'h5B;
      4'h3: seg_lut = 7'h4F;
      4'h4: seg_lut = 7'h66;
      4'h5: seg_lut = 7'h6D;
      4'h6: seg_lut = 7'h7D;
      4'h7: seg_lut = 7'h07;
      4'h8: seg_lut = 7'h7F;
      4'h9: seg_lut = 7'h6F;
      4'hA: seg_lut = 7'h77;
      4'hB: seg_lut = 7'h7C;
      4'hC: seg_lut = 7'h39;
      4'hD: seg_lut = 7'h5E;
      4'hE: seg_lut = 7'h79;
      default: seg_lut = 7'h71;
    endcase
  endfunction

  // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
  always_comb begin
    dd_adj = dd_q;
    for (int k = 0; k < 5; k++) begin
      if (dd_q[DATA_W + 4*k +: 4] >= 4'd5)
        dd_adj[DATA_W + 4*k +: 4] = dd_q[DATA_W + 4*k +: 4] + 4'd3;
    end
    dd_next = {dd_adj[SH_W-2:0], 1'b0};
  end

  always_comb begin
    top_nz   = base_q && (dd_q[SH_W-1 -: 4] != 4'd0);
    nz_above = 1'b0;
    blank    = 4'b0000;
    for (int k = 0; k < 4; k++)
      dig[k] = base_q ? dd_q[DATA_W + 4*k +: 4] : data_q[4*k +: 4];
    for (int k = 3; k >= 1; k--) begin
      nz_above = nz_above | (dig[k] != 4'd0);
      blank[k] = blz_q && !nz_above;
    end
    for (int k = 0; k < 4; k++) begin
      if (top_nz)
        new_seg[k] = ~7'h40;
      else if (blank[k])
        new_seg[k] = 7'h7F;
      else
        new_seg[k] = ~seg_lut(dig[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      data_q     <= '0;
      base_q     <= 1'b0;
      blz_q      <= 1'b0;
      dd_q       <= '0;
      iter_q     <= '0;
      disp_hex_q <= 1'b0;
      ovf        <= 1'b0;
      for (int k = 0; k < 4; k++) disp_q[k] <= 7'h7F;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            base_q <= in_base;
            blz_q  <= blank_lz;
            if (in_base) begin
              dd_q   <= {20'd0, in_data};
              iter_q <= '0;
              state  <= CONV;
            end else begin
              state  <= LATCH;
            end
          end
        end
        CONV: begin
          dd_q   <= dd_next;
          iter_q <= iter_q + 5'd1;
          if (iter_q == ITER_LAST) state <= LATCH;
        end
        LATCH: begin
          disp_q     <= new_seg;
          disp_hex_q <= !base_q;
          ovf        <= top_nz;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign idx_next = idx + 2'd1;

  // Scan outputs refresh only on the slot wrap, for the slot being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
      an_n     <= 4'b1110;
      seg_n    <= 7'h7F;
      dp_n     <= 1'b1;
    end else if (scan_cnt == CNT_LAST) begin
      scan_cnt <= '0;
      idx      <= idx_next;
      an_n     <= ~(4'b0001 << idx_next);
      seg_n    <= disp_q[idx_next];
      dp_n     <= !((idx_next == 2'd0) && disp_hex_q);
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seg_disp_driver.sv
// Directed bench for seg_disp_driver with REFRESH_DIV=4: hex, decimal, overflow,
// leading-zero blanking, busy-time offers and reset abort.
module tb_seg_disp_driver;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_base = 1'b0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        ovf;

  int total = 0;
  int bad = 0;
  int seen4_cnt = 0;
  int nonblank_cnt = 0;
  logic [6:0] exp_q[$];

  seg_disp_driver #(.REFRESH_DIV(DIV), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_base(in_base), .blank_lz(blank_lz),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .ovf(ovf)
  );

  // clock / monitors
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (an_n == 4'b1110 && seg_n == 7'h19) seen4_cnt++;
    if (seg_n != 7'h7F) nonblank_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push4(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    exp_q.push_back(s0);
    exp_q.push_back(s1);
    exp_q.push_back(s2);
    exp_q.push_back(s3);
  endtask

  // Let a full refresh pass, then compare each slot against the queued patterns.
  task automatic check_slots(input string tag, input logic [3:0] dp_exp);
    logic [6:0] e;
    logic [3:0] an_exp;
    bit found;
    repeat (4*DIV + 2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      an_exp = ~(4'b0001 << k);
      found = 1'b0;
      for (int t = 0; t < 8*DIV && !found; t++) begin
        @(negedge clk);
        if (an_n == an_exp) found = 1'b1;
      end
      if (!found) begin
        check($sformatf("%s_slot%0d_timeout", tag, k), 32'd0, 32'd1);
      end else begin
        check($sformatf("%s_slot%0d_seg", tag, k), {25'd0, seg_n}, {25'd0, e});
        check($sformatf("%s_slot%0d_dp", tag, k), {31'd0, dp_n}, {31'd0, dp_exp[k]});
      end
    end
  endtask

  task automatic send(input logic [15:0] d, input logic base, input logic blz, output int lows);
    int t;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_base = base; blank_lz = blz;
    t = 0;
    while (!in_ready && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) check("send_wait_ready", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lows = 0;
    while (!in_ready && lows < 60) begin
      lows++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lows;
    int base_cnt;

    // 1: reset
    repeat (3) @(negedge clk);
    check("rst_seg", {25'd0, seg_n}, 32'h7F);
    check("rst_an", {28'd0, an_n}, 32'b1110);
    check("rst_dp", {31'd0, dp_n}, 32'd1);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    push4(7'h7F, 7'h7F, 7'h7F, 7'h7F);
    check_slots("rst", 4'b1111);

    // 2: hex 1F2A, no blanking
    send(16'h1F2A, 1'b0, 1'b0, lows);
    check("hex_busy", lows, 32'd1);
    check("hex_ovf", {31'd0, ovf}, 32'd0);
    push4(7'h08, 7'h24, 7'h0E, 7'h79);
    check_slots("hex", 4'b1110);

    // 3: decimal 255 with blanking
    send(16'h00FF, 1'b1, 1'b1, lows);
    check("dec_busy", lows, 32'd17);
    push4(7'h12, 7'h12, 7'h24, 7'h7F);
    check_slots("dec255", 4'b1111);

    // 4: decimal overflow, then hex zero with blanking
    send(16'd10000, 1'b1, 1'b0, lows);
    check("ovf_busy", lows, 32'd17);
    check("ovf_set", {31'd0, ovf}, 32'd1);
    push4(7'h3F, 7'h3F, 7'h3F, 7'h3F);
    check_slots("ovf", 4'b1111);
    send(16'h0000, 1'b0, 1'b1, lows);
    check("ovf_clr", {31'd0, ovf}, 32'd0);
    push4(7'h40, 7'h7F, 7'h7F, 7'h7F);
    check_slots("hex0", 4'b1110);

    // 5: offer held through CONV of 1234, data changed to 42
    base_cnt = seen4_cnt;
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'd1234; in_base = 1'b1; blank_lz = 1'b1;
    check("t5_ready_idle", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_data = 16'd42;
    lows = 0;
    while (!in_ready && lows < 60) begin
      lows++;
      @(negedge clk);
    end
    check("t5_busy1234", lows, 32'd17);
    check("t5_ready_gap", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lows = 0;
    while (!in_ready && lows < 60) begin
      lows++;
      @(negedge clk);
    end
    check("t5_busy42", lows, 32'd17);
    check("t5_1234_shown", {31'd0, (seen4_cnt != base_cnt)}, 32'd1);
    push4(7'h24, 7'h19, 7'h7F, 7'h7F);
    check_slots("t5_42", 4'b1111);

    // 6: reset in the middle of converting 9999
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'd9999; in_base = 1'b1; blank_lz = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("t6_busy", {31'd0, in_ready}, 32'd0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ready", {31'd0, in_ready}, 32'd1);
    check("t6_rst_seg", {25'd0, seg_n}, 32'h7F);
    @(negedge clk);
    rst_n = 1'b1;
    base_cnt = nonblank_cnt;
    repeat (40) @(negedge clk);
    check("t6_no_partial", nonblank_cnt - base_cnt, 32'd0);
    check("t6_ready", {31'd0, in_ready}, 32'd1);
    check("t6_ovf", {31'd0, ovf}, 32'd0);
    push4(7'h7F, 7'h7F, 7'h7F, 7'h7F);
    check_slots("t6", 4'b1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
